pattern_scan_arb: RTL and testbench

Controller that shares one serial Moore "1011" pattern detector between NREQ requesters. It round-robin grants one requester at a time and captures that requester's word. It clears the detector, shifts the word through it MSB-first, and counts the matches. It then returns the count with a one-cycle done pulse tagged with the requester ID. It sits between word-parallel clients and the bit-serial detector datapath in the FSM library.

---
 rtl/pattern_scan_pkg.sv | 30 +++
 rtl/pattern_det_1011.sv | 46 ++++
 rtl/pattern_scan_arb.sv | 144 ++++++++++++++
 tb/tb_pattern_scan_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the pattern_scan_arb controller and its
// serial "1011" detector.
package pattern_scan_pkg;

  // Controller sequencing: grant/capture, clear detector, shift word, flush, report.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // Detector states are named after the longest pattern prefix seen so far.
  typedef enum logic [2:0] {
    D_S0    = 3'd0,
    D_S1    = 3'd1,
    D_S10   = 3'd2,
    D_S101  = 3'd3,
    D_S1011 = 3'd4
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pattern_det_1011.sv
// Serial Moore detector for PATTERN (1011); out is high only in S1011, so it
// reports the bit consumed on the previous cycle.
// Build option: PATTERN_SCAN_OVERLAP_EN selects overlapping detection; when
// undefined a match restarts the search from scratch.
module pattern_det_1011
  import pattern_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in,
  output logic out
);

  det_state_e state_q, state_d;

  // Next-state: each state advances on the next expected pattern bit.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      D_S0:    state_d = (in == PATTERN[3]) ? D_S1    : D_S0;
      D_S1:    state_d = (in == PATTERN[2]) ? D_S10   : D_S1;
      D_S10:   state_d = (in == PATTERN[1]) ? D_S101  : D_S0;
      D_S101:  state_d = (in == PATTERN[0]) ? D_S1011 : D_S10;
`ifdef PATTERN_SCAN_OVERLAP_EN
      // Trailing "1" or "10" of the match is reused as a new prefix.
      D_S1011: state_d = in ? D_S1 : D_S10;
`else
      // Only a fresh leading 1 survives; the matched bits are consumed.
      D_S1011: state_d = in ? D_S1 : D_S0;
`endif
      default: state_d = D_S0;
    endcase
  end

  // State register with synchronous reset and synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset || clr) state_q <= D_S0;
    else              state_q <= state_d;
  end

  assign out = (state_q == D_S1011);

endmodule

// File: rtl/pattern_scan_arb.sv
// Round-robin arbiter that lends one serial 1011 detector to NREQ word-parallel
// requesters: grant, capture, shift MSB-first, count matches, report with done.
// Build option: PATTERN_SCAN_OVERLAP_EN (detector overlap mode, see pattern_det_1011).
module pattern_scan_arb
  import pattern_scan_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int WORD_W = 8,
  parameter  int CNT_W  = 4,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   ser_bit
);

  localparam int          IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  ctrl_state_e        state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [ID_W-1:0]    pick;
  logic [CNT_W-1:0]   cnt_next;
  logic               det_clr;
  logic               det_out;

  // First requesting index after `last`, wrapping; `last` itself is lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] cand;
    sel = last;
    for (int k = NREQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % NREQ);
      if (r[cand]) sel = cand;
    end
    return sel;
  endfunction

  assign pick     = rr_pick(req, last_q);
  assign cnt_next = det_out ? CNT_W'(sat_inc(32'(cnt_q), CNT_MAX)) : cnt_q;

  // Grant pulse is combinational so the winner is told in the same IDLE cycle it is captured.
  always_comb begin
    gnt = '0;
    if (!reset && (state_q == ST_IDLE) && (|req)) gnt[pick] = 1'b1;
  end

  // Controller next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    det_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          last_d  = pick;
          id_d    = pick;
          sreg_d  = req_data[int'(pick)*WORD_W +: WORD_W];
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        det_clr = 1'b1;
        cnt_d   = '0;
        idx_d   = IDX_W'(WORD_W - 1);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // det_out here reflects the bit shifted on the previous cycle.
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_next;
        if (idx_q == '0) state_d = ST_FLUSH;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      ST_FLUSH: begin
        // Last bit's Moore output is visible now; publish so it shows on the done cycle.
        cnt_d       = cnt_next;
        match_cnt_d = cnt_next;
        done_id_d   = id_q;
        state_d     = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_W'(NREQ - 1);
      id_q        <= '0;
      sreg_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      sreg_q      <= sreg_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign ser_bit   = (state_q == ST_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;

  pattern_det_1011 u_det (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .in    (ser_bit),
    .out   (det_out)
  );

endmodule

// File: tb/tb_pattern_scan_arb.sv
// Scoreboard bench for pattern_scan_arb: grants are predicted from the
// round-robin rule, match counts from a substring count over the word.
module tb_pattern_scan_arb;

  localparam int NREQ     = 2;
  localparam int WORD_W   = 8;
  localparam int CNT_W    = 4;
  localparam int ID_W     = 1;
  localparam int S_WORD_W = 32;
  localparam int S_CNT_W  = 2;
`ifdef PATTERN_SCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WORD_W-1:0] req_data = '0;
  logic [NREQ-1:0]        gnt;
  logic                   busy, done, ser_bit;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       match_cnt;

  // Saturation instance
  logic [NREQ-1:0]          s_req = '0;
  logic [NREQ*S_WORD_W-1:0] s_req_data = '0;
  logic [NREQ-1:0]          s_gnt;
  logic                     s_busy, s_done, s_ser_bit;
  logic [ID_W-1:0]          s_done_id;
  logic [S_CNT_W-1:0]       s_match_cnt;

  pattern_scan_arb #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt),
    .ser_bit(ser_bit)
  );

  pattern_scan_arb #(.NREQ(NREQ), .WORD_W(S_WORD_W), .CNT_W(S_CNT_W)) dut_sat (
    .clk(clk), .reset(reset), .req(s_req), .req_data(s_req_data), .gnt(s_gnt),
    .busy(s_busy), .done(s_done), .done_id(s_done_id), .match_cnt(s_match_cnt),
    .ser_bit(s_ser_bit)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Reference: count of 1011 occurrences in the MSB-first bit stream, saturated.
  function automatic int model_count(input logic [63:0] w, input int width, input int cnt_w);
    int n = 0;
    int i = 0;
    int max_c = (1 << cnt_w) - 1;
    logic [3:0] win;
    while (i + 4 <= width) begin
      for (int b = 0; b < 4; b++) win[3-b] = w[width-1-i-b];
      if (win == 4'b1011) begin
        n++;
        i += OVERLAP ? 1 : 4;
      end else begin
        i++;
      end
    end
    return (n > max_c) ? max_c : n;
  endfunction

  // Reference round-robin: first requester after last, wrapping; -1 if none.
  function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  typedef struct { int id; int cnt; int cyc; } exp_t;
  exp_t sb_q[$];
  exp_t ssb_q[$];

  int   cycle = 0;
  logic rst_sampled = 1'b1;
  always @(posedge clk) begin
    cycle       <= cycle + 1;
    rst_sampled <= reset;
  end

  // Main-instance model state
  int              last_g       = NREQ - 1;
  int              last_gnt_cyc = -1000;
  int              held_id      = 0;
  int              held_cnt     = 0;
  int              ser_start    = -1000;
  logic [WORD_W-1:0] ser_word   = '0;
  logic [NREQ-1:0] gnt_seen     = '0;

  // Main monitor: predicts gnt/busy/ser_bit per cycle and scores done results.
  always @(negedge clk) begin
    int p;
    logic [NREQ-1:0] exp_gnt;
    logic exp_busy, exp_ser;
    exp_t e;
    gnt_seen = gnt;
    if (rst_sampled) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ser_bit", ser_bit, 0);
      check("rst_done_id", done_id, 0);
      check("rst_match_cnt", match_cnt, 0);
      if (reset) check("rst_gnt", gnt, 0);
      sb_q.delete();
      last_g = NREQ - 1; last_gnt_cyc = -1000;
      held_id = 0; held_cnt = 0; ser_start = -1000;
    end
    if (!reset) begin
      exp_busy = (cycle > last_gnt_cyc) && (cycle <= last_gnt_cyc + WORD_W + 3);
      check("busy", busy, exp_busy);
      exp_gnt = '0;
      p = exp_busy ? -1 : rr_model(req, last_g);
      if (p >= 0) exp_gnt[p] = 1'b1;
      check("gnt", gnt, exp_gnt);
      exp_ser = 1'b0;
      if (cycle >= ser_start && cycle < ser_start + WORD_W)
        exp_ser = ser_word[WORD_W-1-(cycle-ser_start)];
      check("ser_bit", ser_bit, exp_ser);
      if (p >= 0) begin
        ser_word = req_data[p*WORD_W +: WORD_W];
        e.id  = p;
        e.cnt = model_count(64'(ser_word), WORD_W, CNT_W);
        e.cyc = cycle + WORD_W + 3;
        sb_q.push_back(e);
        ser_start = cycle + 2; last_g = p; last_gnt_cyc = cycle;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cycle, e.cyc);
          check("done_id", done_id, e.id);
          check("match_cnt", match_cnt, e.cnt);
          held_id = e.id; held_cnt = e.cnt;
        end
      end else begin
        check("held_done_id", done_id, held_id);
        check("held_match_cnt", match_cnt, held_cnt);
        if (sb_q.size() > 0 && cycle > sb_q[0].cyc) begin
          fail_now("done_late");
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Saturation-instance monitor
  int              s_last = NREQ - 1;
  logic [NREQ-1:0] s_gnt_seen = '0;
  always @(negedge clk) begin
    int p;
    logic [NREQ-1:0] exp_gnt;
    exp_t e;
    s_gnt_seen = s_gnt;
    if (rst_sampled) begin
      ssb_q.delete();
      s_last = NREQ - 1;
    end
    if (!reset) begin
      if (s_gnt != '0) begin
        p = rr_model(s_req, s_last);
        exp_gnt = '0;
        if (p >= 0) exp_gnt[p] = 1'b1;
        check("s_gnt", s_gnt, exp_gnt);
        if (p >= 0) begin
          e.id  = p;
          e.cnt = model_count(64'(s_req_data[p*S_WORD_W +: S_WORD_W]), S_WORD_W, S_CNT_W);
          e.cyc = cycle + S_WORD_W + 3;
          ssb_q.push_back(e);
          s_last = p;
        end
      end
      if (s_done) begin
        if (ssb_q.size() == 0) begin
          fail_now("s_done_unexpected");
        end else begin
          e = ssb_q.pop_front();
          check("s_done_cycle", cycle, e.cyc);
          check("s_done_id", s_done_id, e.id);
          check("s_match_cnt", s_match_cnt, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req[i] with word w, wait for its grant, then drop req unless keep.
  task automatic send(input int i, input logic [WORD_W-1:0] w, input bit keep);
    int t = 0;
    req[i] = 1'b1;
    req_data[i*WORD_W +: WORD_W] = w;
    do begin tick(); t++; end while (!gnt_seen[i] && t < 200);
    if (!gnt_seen[i]) fail_now("gnt_timeout");
    if (!keep) req[i] = 1'b0;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((busy || sb_q.size() != 0) && t < 500) begin tick(); t++; end
    if (busy || sb_q.size() != 0) fail_now("quiet_timeout");
  endtask

  task automatic s_send(input logic [S_WORD_W-1:0] w);
    int t = 0;
    s_req[0] = 1'b1;
    s_req_data[0 +: S_WORD_W] = w;
    do begin tick(); t++; end while (!s_gnt_seen[0] && t < 200);
    if (!s_gnt_seen[0]) fail_now("s_gnt_timeout");
    s_req[0] = 1'b0;
    t = 0;
    while ((s_busy || ssb_q.size() != 0) && t < 500) begin tick(); t++; end
    if (s_busy || ssb_q.size() != 0) fail_now("s_quiet_timeout");
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] pool [6] = '{8'hB6, 8'hBB, 8'h2D, 8'hFF, 8'h00, 8'hDB};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return WORD_W'($urandom);
  endfunction

  initial begin
    int t;
    // Reset held from time zero
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Single word with pattern hits
    send(0, 8'hB6, 1'b0);
    wait_quiet();

    // Requester 1 queues two words back-to-back
    send(1, 8'h00, 1'b1);
    send(1, 8'hFF, 1'b0);
    wait_quiet();

    // Both requesting continuously: grants must alternate
    req_data = {rand_word(), rand_word()};
    req = 2'b11;
    for (int n = 0; n < 6; n++) begin
      t = 0;
      do begin tick(); t++; end while (gnt_seen == '0 && t < 100);
      if (gnt_seen == '0) fail_now("alt_gnt_timeout");
      for (int i = 0; i < NREQ; i++)
        if (gnt_seen[i]) req_data[i*WORD_W +: WORD_W] = rand_word();
    end
    req = '0;
    wait_quiet();

    // Request raised while busy
    send(0, rand_word(), 1'b0);
    repeat (3) tick();
    send(1, rand_word(), 1'b0);
    wait_quiet();

    // Reset mid-SHIFT with req0 pending across reset release
    send(0, 8'hBB, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    req[0] = 1'b1;
    req_data[0 +: WORD_W] = 8'hB6;
    repeat (3) tick();
    reset = 1'b0;
    send(0, 8'hB6, 1'b0);
    wait_quiet();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt_seen[i]) begin
          if ($urandom_range(0, 1) == 0) req_data[i*WORD_W +: WORD_W] = rand_word();
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 9) < 3) begin
          req_data[i*WORD_W +: WORD_W] = rand_word();
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    wait_quiet();

    // Wide word, narrow saturating counter
    s_send(32'hBBBBBBBB);
    s_send(32'hFFFFFFFF);
    s_send(32'h0000000B);
    s_send(32'(($urandom)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
